// File: rtl/debug_hart_ctrl_if.sv
// debug_hart_ctrl_if
//   APB completer bus used by debug_hart_ctrl.
//   Signals:
//     PSEL, PENABLE, PWRITE : transfer control (requester -> completer)
//     PADDR[4:0]            : byte address
//     PWDATA[7:0]           : write data
//     PRDATA[7:0]           : read data (completer -> requester)
//     PREADY                : transfer ready (completer -> requester)
//     PSLVERR               : unmapped-access error (completer -> requester)
//   Modports: master (debugger interconnect side), slave (register block side).
`timescale 1ns/1ps
interface debug_hart_ctrl_if;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [4:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/debug_hart_ctrl.sv
// debug_hart_ctrl
//   APB debug control/status register block for NUM_HARTS harts: per-hart
//   halt requests, single-step masking windows, timed reset pulses and
//   sticky halt-event flags with an optional interrupt.
//
//   Optional feature macro: DEBUG_HART_IRQ_EN
//     defined   : IRQEN register at 0x07, registered IRQ = |(EVENT & IRQEN)
//     undefined : 0x07 reads 0 and ignores writes, IRQ tied low
//
//   Ports:
//     PCLK          in   clock, rising edge
//     PRESETn       in   asynchronous active-low reset
//     apb           --   APB completer (debug_hart_ctrl_if.slave)
//     DEBUG_REQUEST out  per-hart halt request (masked during a step window)
//     DEBUG_ACK     in   per-hart request acknowledge
//     RESET_REQUEST out  per-hart reset pulse
//     HALTED        in   per-hart halted status, synchronous to PCLK
//     IRQ           out  halt-event interrupt
//
//   Register map: 0x00 HALTREQ (RW, write toggles), 0x01 STEP (WO),
//   0x02 RESET (WO), 0x03 STATUS (RO), 0x04 ACK (RO), 0x05 EVENT (W1C),
//   0x06 ID (RO), 0x07 IRQEN (RW, optional). 0x08..0x1F raise PSLVERR.
`timescale 1ns/1ps
module debug_hart_ctrl #(
  parameter int NUM_HARTS    = 2,
  parameter int RESET_CYCLES = 3,
  parameter int STEP_CYCLES  = 7
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  debug_hart_ctrl_if.slave     apb,
  output logic [NUM_HARTS-1:0] DEBUG_REQUEST,
  input  logic [NUM_HARTS-1:0] DEBUG_ACK,
  output logic [NUM_HARTS-1:0] RESET_REQUEST,
  input  logic [NUM_HARTS-1:0] HALTED,
  output logic                 IRQ
);

  localparam logic [4:0] A_HALTREQ = 5'h00;
  localparam logic [4:0] A_STEP    = 5'h01;
  localparam logic [4:0] A_RESET   = 5'h02;
  localparam logic [4:0] A_STATUS  = 5'h03;
  localparam logic [4:0] A_ACK     = 5'h04;
  localparam logic [4:0] A_EVENT   = 5'h05;
  localparam logic [4:0] A_ID      = 5'h06;
  localparam logic [4:0] A_IRQEN   = 5'h07;

  localparam logic [7:0] STEP_LOAD  = 8'(STEP_CYCLES);
  localparam logic [7:0] RESET_LOAD = 8'(RESET_CYCLES);

  logic                      prev_enable_q;
  logic [NUM_HARTS-1:0]      halt_req_q, halt_req_d;
  logic [NUM_HARTS-1:0][7:0] step_cnt_q, step_cnt_d;
  logic [NUM_HARTS-1:0][7:0] rst_cnt_q, rst_cnt_d;
  logic [NUM_HARTS-1:0]      event_q, event_d;
  logic [NUM_HARTS-1:0]      halted_q;

  logic                 access, addr_err, commit;
  logic [NUM_HARTS-1:0] wdata;
  logic                 wr_halt, wr_step, wr_reset, wr_event;
  logic [7:0]           rdata;
  logic                 unused_wdata;

  // Bits of PWDATA above NUM_HARTS have no register behind them.
  assign unused_wdata = ^apb.PWDATA;

  assign access   = apb.PSEL & apb.PENABLE;
  assign addr_err = (apb.PADDR > A_IRQEN);
  // prev_enable_q suppresses repeat commits while PENABLE is held high.
  assign commit   = access & apb.PWRITE & ~prev_enable_q & ~addr_err;
  assign wdata    = apb.PWDATA[NUM_HARTS-1:0];

  assign wr_halt  = commit & (apb.PADDR == A_HALTREQ);
  assign wr_step  = commit & (apb.PADDR == A_STEP);
  assign wr_reset = commit & (apb.PADDR == A_RESET);
  assign wr_event = commit & (apb.PADDR == A_EVENT);

`ifdef DEBUG_HART_IRQ_EN
  logic [NUM_HARTS-1:0] irqen_q;
  logic                 irq_q;
  logic                 wr_irqen;

  assign wr_irqen = commit & (apb.PADDR == A_IRQEN);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      irqen_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      if (wr_irqen) irqen_q <= wdata;
      irq_q <= |(event_q & irqen_q);
    end
  end

  assign IRQ = irq_q;
`else
  assign IRQ = 1'b0;
`endif

  always_comb begin
    halt_req_d = halt_req_q;
    if (wr_halt) halt_req_d = halt_req_q ^ wdata;

    // A new rising edge of HALTED beats a simultaneous W1C on the same bit.
    event_d = event_q;
    if (wr_event) event_d = event_q & ~wdata;
    event_d = event_d | (HALTED & ~halted_q);

    // Down-counters saturate at zero; a command reloads rather than adds.
    for (int i = 0; i < NUM_HARTS; i++) begin
      step_cnt_d[i] = (step_cnt_q[i] != 8'd0) ? step_cnt_q[i] - 8'd1 : 8'd0;
      rst_cnt_d[i]  = (rst_cnt_q[i]  != 8'd0) ? rst_cnt_q[i]  - 8'd1 : 8'd0;
      if (wr_step  && wdata[i]) step_cnt_d[i] = STEP_LOAD;
      if (wr_reset && wdata[i]) rst_cnt_d[i]  = RESET_LOAD;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      prev_enable_q <= 1'b0;
      halt_req_q    <= '1;
      step_cnt_q    <= '0;
      rst_cnt_q     <= '0;
      event_q       <= '0;
      halted_q      <= '0;
    end else begin
      prev_enable_q <= apb.PENABLE;
      halt_req_q    <= halt_req_d;
      step_cnt_q    <= step_cnt_d;
      rst_cnt_q     <= rst_cnt_d;
      event_q       <= event_d;
      halted_q      <= HALTED;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_HARTS; i++) begin
      DEBUG_REQUEST[i] = halt_req_q[i] & (step_cnt_q[i] == 8'd0);
      RESET_REQUEST[i] = (rst_cnt_q[i] != 8'd0);
    end
  end

  // Read mux: unmapped and write-only addresses return zero.
  always_comb begin
    rdata = '0;
    case (apb.PADDR)
      A_HALTREQ: rdata[NUM_HARTS-1:0] = halt_req_q;
      A_STATUS:  rdata[NUM_HARTS-1:0] = HALTED;
      A_ACK:     rdata[NUM_HARTS-1:0] = DEBUG_ACK;
      A_EVENT:   rdata[NUM_HARTS-1:0] = event_q;
      A_ID:      rdata = {3'(NUM_HARTS - 1), 5'h02};
`ifdef DEBUG_HART_IRQ_EN
      A_IRQEN:   rdata[NUM_HARTS-1:0] = irqen_q;
`endif
      default:   rdata = '0;
    endcase
  end

  assign apb.PRDATA  = rdata;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = access & addr_err;

endmodule

// File: tb/tb_debug_hart_ctrl.sv
`timescale 1ns/1ps
module tb_debug_hart_ctrl;
  localparam int N = 2;
`ifdef DEBUG_HART_IRQ_EN
  localparam logic [7:0] IRQ_EXP   = 8'h01;
  localparam logic [7:0] IRQEN_EXP = 8'h01;
`else
  localparam logic [7:0] IRQ_EXP   = 8'h00;
  localparam logic [7:0] IRQEN_EXP = 8'h00;
`endif

  logic         PCLK = 1'b0;
  logic         PRESETn = 1'b0;
  logic [N-1:0] DEBUG_REQUEST, DEBUG_ACK, RESET_REQUEST, HALTED;
  logic         IRQ;

  debug_hart_ctrl_if bus ();

  debug_hart_ctrl #(.NUM_HARTS(N), .RESET_CYCLES(3), .STEP_CYCLES(7)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .apb(bus),
    .DEBUG_REQUEST(DEBUG_REQUEST), .DEBUG_ACK(DEBUG_ACK),
    .RESET_REQUEST(RESET_REQUEST), .HALTED(HALTED), .IRQ(IRQ)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  typedef struct { int cyc; int sel; logic [7:0] exp; string name; } pin_t;
  typedef struct { string name; bit rd; logic [7:0] data; bit err; } acc_t;
  pin_t pin_q[$];
  acc_t acc_q[$];
  int passed = 0;
  int total  = 0;

  function automatic void check(string name, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
  endfunction

  function automatic void push_pin(int c, int sel, logic [7:0] e, string n);
    pin_q.push_back(pin_t'{c, sel, e, n});
  endfunction

  // Pin monitor: compares output pins at the cycle each expectation names.
  pin_t       p_mon;
  logic [7:0] p_act;
  always @(negedge PCLK) begin
    while (pin_q.size() > 0 && pin_q[0].cyc <= cyc) begin
      p_mon = pin_q.pop_front();
      case (p_mon.sel)
        0:       p_act = 8'(DEBUG_REQUEST);
        1:       p_act = 8'(RESET_REQUEST);
        default: p_act = 8'(IRQ);
      endcase
      if (p_mon.cyc < cyc) begin
        total++;
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)", p_mon.name, p_mon.cyc, cyc);
      end else begin
        check(p_mon.name, p_act, p_mon.exp);
      end
    end
  end

  // Bus monitor: checks the first cycle of every access phase.
  logic mon_pen = 1'b0;
  acc_t a_mon;
  always @(negedge PCLK) begin
    if (bus.PSEL && bus.PENABLE && !mon_pen) begin
      if (acc_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_access: addr 0x%02h with no expectation queued", bus.PADDR);
      end else begin
        a_mon = acc_q.pop_front();
        check({a_mon.name, "_pslverr"}, 8'(bus.PSLVERR), 8'(a_mon.err));
        check({a_mon.name, "_pready"}, 8'(bus.PREADY), 8'h01);
        if (a_mon.rd) check(a_mon.name, bus.PRDATA, a_mon.data);
      end
    end
    mon_pen = bus.PSEL && bus.PENABLE;
  end

  // Drives setup and access phase; returns just after the commit edge with
  // the bus still in the access phase.
  task automatic apb_start(input logic [4:0] a, input logic [7:0] d, input bit wr,
                           input logic [7:0] exp, input string n, output int t);
    acc_q.push_back(acc_t'{n, !wr, exp, (a > 5'h07)});
    @(posedge PCLK); #1;
    bus.PSEL = 1'b1; bus.PWRITE = wr; bus.PADDR = a; bus.PWDATA = d; bus.PENABLE = 1'b0;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    @(posedge PCLK); #1;
    t = cyc;
  endtask

  task automatic apb_end(input int hold);
    if (hold > 0) begin
      repeat (hold) @(posedge PCLK);
      #1;
    end
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d, input string n, output int t);
    apb_start(a, d, 1'b1, 8'h00, n, t);
    apb_end(0);
  endtask

  task automatic rd(input logic [4:0] a, input logic [7:0] exp, input string n);
    int t;
    apb_start(a, 8'h00, 1'b0, exp, n, t);
    apb_end(0);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(posedge PCLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t, t2, c;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = '0; bus.PWDATA = '0;
    HALTED = '0; DEBUG_ACK = '0; PRESETn = 1'b0;

    // Reset state
    repeat (3) @(posedge PCLK);
    #1; PRESETn = 1'b1; c = cyc;
    push_pin(c, 0, 8'h03, "rst_dreq");
    push_pin(c, 1, 8'h00, "rst_rreq");
    push_pin(c, 2, 8'h00, "rst_irq");
    rd(5'h00, 8'h03, "rst_haltreq");
    rd(5'h06, 8'h22, "rst_id");
    rd(5'h05, 8'h00, "rst_event");
    rd(5'h07, 8'h00, "rst_irqen");
    rd(5'h01, 8'h00, "step_reads0");

    // HALTREQ toggle, upper bits ignored
    wr(5'h00, 8'h01, "halt_toggle", t);
    push_pin(t, 0, 8'h02, "dreq_toggled");
    rd(5'h00, 8'h02, "haltreq_rd");
    wr(5'h00, 8'h81, "halt_hibits", t);
    rd(5'h00, 8'h03, "haltreq_hibits");

    // Step window on hart 1, restarted 4 cycles in
    wr(5'h01, 8'h02, "step", t);
    for (int k = 0; k < 4; k++) push_pin(t + k, 0, 8'h01, "step_win");
    @(posedge PCLK);
    wr(5'h01, 8'h02, "step_restart", t2);
    for (int k = 0; k < 7; k++) push_pin(t2 + k, 0, 8'h01, "step_rewin");
    push_pin(t2 + 7, 0, 8'h03, "step_end");
    wait_until(t2 + 9);

    // HALTREQ toggled twice during a window: mask holds until count expires
    wr(5'h01, 8'h02, "step2", t);
    for (int k = 0; k < 3; k++) push_pin(t + k, 0, 8'h01, "step2_win");
    wr(5'h00, 8'h02, "halt_in_win_a", t2);
    for (int k = 0; k < 3; k++) push_pin(t2 + k, 0, 8'h01, "step2_win_a");
    wr(5'h00, 8'h02, "halt_in_win_b", t2);
    push_pin(t2, 0, 8'h01, "step2_still_masked");
    push_pin(t + 7, 0, 8'h03, "step2_end");
    wait_until(t + 9);

    // Reset pulse, 3 cycles
    wr(5'h02, 8'h01, "rst_pulse", t);
    for (int k = 0; k < 3; k++) push_pin(t + k, 1, 8'h01, "rst_pulse_hi");
    push_pin(t + 3, 1, 8'h00, "rst_pulse_lo");
    push_pin(t + 4, 1, 8'h00, "rst_pulse_lo2");
    wait_until(t + 5);

    // PENABLE held 3 extra cycles: single commit
    apb_start(5'h02, 8'h01, 1'b1, 8'h00, "rst_hold", t);
    for (int k = 0; k < 3; k++) push_pin(t + k, 1, 8'h01, "hold_pulse_hi");
    for (int k = 3; k < 7; k++) push_pin(t + k, 1, 8'h00, "hold_pulse_lo");
    apb_end(3);
    wait_until(t + 7);

    // Reset pulse reload before expiry
    wr(5'h02, 8'h01, "rst_a", t);
    for (int k = 0; k < 3; k++) push_pin(t + k, 1, 8'h01, "reload_hi_a");
    wr(5'h02, 8'h01, "rst_b", t2);
    for (int k = 0; k < 3; k++) push_pin(t2 + k, 1, 8'h01, "reload_hi_b");
    push_pin(t2 + 3, 1, 8'h00, "reload_lo");
    wait_until(t2 + 4);

    // Halt events, status, ack
    HALTED = 2'b10;
    DEBUG_ACK = 2'b01;
    rd(5'h05, 8'h02, "event_set");
    rd(5'h03, 8'h02, "status");
    rd(5'h04, 8'h01, "ack");
    wr(5'h05, 8'h02, "event_w1c", t);
    rd(5'h05, 8'h00, "event_cleared");
    HALTED[1] = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    fork
      wr(5'h05, 8'h02, "w1c_vs_rise", t);
      begin
        repeat (2) @(posedge PCLK);
        #1; HALTED[1] = 1'b1;
      end
    join
    rd(5'h05, 8'h02, "w1c_set_wins");

    // Interrupt
    wr(5'h05, 8'h03, "ev_clr_all", t);
    rd(5'h05, 8'h00, "ev_all_clear");
    wr(5'h07, 8'h01, "irqen_wr", t);
    rd(5'h07, IRQEN_EXP, "irqen_rd");
    @(posedge PCLK); #1;
    HALTED[0] = 1'b1; c = cyc;
    push_pin(c, 2, 8'h00, "irq_pre");
    push_pin(c + 1, 2, 8'h00, "irq_lat1");
    push_pin(c + 2, 2, IRQ_EXP, "irq_set");
    wait_until(c + 3);
    wr(5'h05, 8'h01, "ev_w1c_irq", t);
    push_pin(t, 2, IRQ_EXP, "irq_at_w1c");
    push_pin(t + 1, 2, 8'h00, "irq_cleared");
    wait_until(t + 2);

    // Unmapped access
    wr(5'h10, 8'hFF, "err_wr", t);
    push_pin(t + 1, 0, 8'h03, "err_no_step");
    push_pin(t + 1, 1, 8'h00, "err_no_rst");
    rd(5'h00, 8'h03, "err_halt_same");
    rd(5'h05, 8'h00, "err_event_same");
    rd(5'h10, 8'h00, "err_rd");

    // Reset in the middle of activity
    HALTED = 2'b00;
    @(posedge PCLK); #1;
    HALTED = 2'b01;
    wr(5'h00, 8'h01, "pre_halt", t);
    wr(5'h01, 8'h03, "pre_step", t);
    wr(5'h02, 8'h03, "pre_rst", t);
    push_pin(t, 0, 8'h00, "pre_dreq");
    push_pin(t, 1, 8'h03, "pre_rreq");
    rd(5'h05, 8'h01, "pre_event");
    #2; PRESETn = 1'b0; c = cyc;
    push_pin(c, 0, 8'h03, "midrst_dreq");
    push_pin(c, 1, 8'h00, "midrst_rreq");
    push_pin(c, 2, 8'h00, "midrst_irq");
    HALTED = 2'b00;
    repeat (2) @(posedge PCLK);
    #1; PRESETn = 1'b1;
    rd(5'h05, 8'h00, "midrst_event");
    rd(5'h00, 8'h03, "midrst_halt");

    for (int i = 0; i < 50 && (pin_q.size() > 0 || acc_q.size() > 0); i++) @(posedge PCLK);
    if (pin_q.size() > 0 || acc_q.size() > 0) begin
      total += pin_q.size() + acc_q.size();
      $display("FAIL drain: %0d pin and %0d bus expectations never checked", pin_q.size(), acc_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
